// File: rtl/sequenciador_pc.sv
// Multicycle PC sequencer: fetches through a req/ack handshake, waits for the
// datapath, then issues exactly one registered PC update per instruction.
module sequenciador_pc #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] instr,
  input  logic        exec_done,
  input  logic        alu_zero,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic [4:0]  reg_sel,
  output logic [2:0]  pc_control,
  output logic [25:0] jump_address,
  output logic [15:0] branch_offset,
  output logic [31:0] retired,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_UPDATE, S_HALTED, S_FAULT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;
  logic [25:0] jump_address_q, jump_address_d;
  logic [15:0] branch_offset_q, branch_offset_d;
  logic [4:0]  reg_sel_q, reg_sel_d;
  logic [2:0]  pc_control_q, pc_control_d;
  logic        imem_req_q, imem_req_d;
  logic        ir_valid_q, ir_valid_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        branch_taken;

  assign opcode = ir_q[31:26];
  assign funct  = ir_q[5:0];
  // alu_zero is consumed on the edge that leaves EXEC, so the registered
  // update fields already carry the latched zero flag into UPDATE.
  assign branch_taken = ((opcode == OP_BEQ) && alu_zero) ||
                        ((opcode == OP_BNE) && !alu_zero);

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = 8'd0;
    ir_d            = ir_q;
    retired_d       = retired_q;
    jump_address_d  = jump_address_q;
    branch_offset_d = branch_offset_q;
    reg_sel_d       = reg_sel_q;
    pc_control_d    = 3'b000;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        state_d = (opcode == OP_HALT) ? S_HALTED : S_EXEC;
      end
      S_EXEC: begin
        if (exec_done) begin
          state_d = S_UPDATE;
          if ((opcode == OP_J) || (opcode == OP_JAL)) begin
            pc_control_d   = 3'b001;
            jump_address_d = ir_q[25:0];
          end else if ((opcode == OP_RTYPE) && (funct == FN_JR)) begin
            pc_control_d = 3'b010;
            reg_sel_d    = ir_q[25:21];
          end else if (branch_taken) begin
            pc_control_d    = 3'b011;
            branch_offset_d = ir_q[15:0] + 16'd1;
          end else begin
            pc_control_d    = 3'b011;
            branch_offset_d = 16'd1;
          end
        end
      end
      S_UPDATE: begin
        retired_d = retired_q + 32'd1;
        state_d   = start ? S_FETCH : S_IDLE;
      end
      S_HALTED: state_d = S_HALTED;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase

    imem_req_d = (state_d == S_FETCH);
    ir_valid_d = (state_d == S_DECODE);
    halted_d   = (state_d == S_HALTED);
    fault_d    = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      wait_cnt_q      <= 8'd0;
      ir_q            <= 32'd0;
      retired_q       <= 32'd0;
      jump_address_q  <= 26'd0;
      branch_offset_q <= 16'd0;
      reg_sel_q       <= 5'd0;
      pc_control_q    <= 3'b000;
      imem_req_q      <= 1'b0;
      ir_valid_q      <= 1'b0;
      halted_q        <= 1'b0;
      fault_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      ir_q            <= ir_d;
      retired_q       <= retired_d;
      jump_address_q  <= jump_address_d;
      branch_offset_q <= branch_offset_d;
      reg_sel_q       <= reg_sel_d;
      pc_control_q    <= pc_control_d;
      imem_req_q      <= imem_req_d;
      ir_valid_q      <= ir_valid_d;
      halted_q        <= halted_d;
      fault_q         <= fault_d;
    end
  end

  assign imem_req      = imem_req_q;
  assign ir            = ir_q;
  assign ir_valid      = ir_valid_q;
  assign reg_sel       = reg_sel_q;
  assign pc_control    = pc_control_q;
  assign jump_address  = jump_address_q;
  assign branch_offset = branch_offset_q;
  assign retired       = retired_q;
  assign halted        = halted_q;
  assign fault         = fault_q;

endmodule

// File: doc/sequenciador_pc.md
Name: sequenciador_pc

Overview:
Multicycle control FSM that sequences the program counter of the processor core. It fetches each instruction through a req/ack handshake with instruction memory and latches it into an instruction register. It then waits for the datapath to finish execution and issues exactly one PC update per instruction by driving the PC block's pc_control, jump_address and branch_offset inputs. In every other cycle it holds pc_control at 3'b000, which makes the PC block hold its value (PC := PC).

Parameters:
TIMEOUT_CYCLES, 16, maximum FETCH cycles without imem_ack before a fault is raised (valid range 1..255).

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous reset, active-low; sampled on rising clk.
start  input  1  level; leaves IDLE when high.
imem_req  output  1  instruction fetch request.
imem_ack  input  1  instruction memory ack; instr is valid in the same cycle.
instr  input  32  instruction word from memory.
exec_done  input  1  datapath finished executing the current instruction.
alu_zero  input  1  ALU zero flag; sampled when exec_done is high.
ir  output  32  instruction register.
ir_valid  output  1  one-cycle pulse in DECODE.
reg_sel  output  5  ir[25:21], the rs index used by the datapath to supply reg_address for JR.
pc_control  output  3  to the PC block: 000 hold, 001 jump, 010 register, 011 relative add.
jump_address  output  26  to the PC block.
branch_offset  output  16  to the PC block; word offset added to PC.
retired  output  32  count of completed PC updates.
halted  output  1  high in HALTED.
fault  output  1  high in FAULT.

Behaviour:
Reset (rst=0 at a clock edge):
- state goes to IDLE.
- ir, jump_address, branch_offset, retired and reg_sel are cleared to 0.
- pc_control=000; imem_req, ir_valid, halted and fault are 0.
- Reset takes priority over every other input, including in the middle of a fetch handshake; imem_req drops at that edge.

States:
- IDLE: pc_control=000. Go to FETCH when start=1.
- FETCH:
  - imem_req=1 and is held until imem_ack.
  - On imem_ack: ir <= instr, then DECODE. The wait counter is cleared.
  - Otherwise the wait counter increments. When it reaches TIMEOUT_CYCLES without ack, go to FAULT.
- DECODE:
  - ir_valid=1 for exactly this cycle.
  - Opcode ir[31:26]=6'b111111 (HALT) goes to HALTED; every other opcode goes to EXEC.
- EXEC: wait for exec_done=1. On that cycle latch alu_zero into taken_z, then go to UPDATE.
- UPDATE: a single cycle in which pc_control is non-zero. Decode by instruction:
  - J (000010) or JAL (000011): pc_control=001, jump_address=ir[25:0].
  - JR (opcode 000000, funct ir[5:0]=001000): pc_control=010, reg_sel=ir[25:21].
  - BEQ (000100) with taken_z=1, or BNE (000101) with taken_z=0: pc_control=011, branch_offset=ir[15:0]+16'd1. This is the MIPS PC+4-relative target. The addition wraps modulo 2^16, so ir[15:0]=16'hFFFF gives offset 0 (a self-loop).
  - Any other instruction, including a branch that is not taken: pc_control=011, branch_offset=16'd1 (PC+4).
  - retired increments by 1 (wraps at 2^32).
  - Next state is FETCH if start=1, otherwise IDLE.
- HALTED: halted=1 and pc_control=000. Only reset exits this state.
- FAULT: fault=1 and pc_control=000. Only reset exits this state.

Output timing and edge cases:
- pc_control, jump_address, branch_offset and reg_sel are registered and are valid during the UPDATE cycle. The PC block therefore captures the new PC on the edge that ends UPDATE.
- exec_done and imem_ack are ignored outside EXEC and FETCH respectively.
- If exec_done and start change in the same cycle, exec_done is handled first; start is sampled only in UPDATE and IDLE.
- Undefined opcodes are treated as sequential.

Latency:
- Minimum 4 cycles per instruction: FETCH (ack immediate), DECODE, EXEC (exec_done immediate), UPDATE.

Test Plan:
1. Sequential op. Release reset, start=1, instr=32'h00000020 (add), ack and exec_done immediate -> UPDATE cycle shows pc_control=011, branch_offset=1; retired=1; back in FETCH 4 cycles after leaving IDLE.
2. Taken BEQ. instr=32'h1000FFFD (BEQ, offset -3), alu_zero=1 at exec_done -> pc_control=011, branch_offset=16'hFFFE. Same instruction with alu_zero=0 -> branch_offset=1. BNE with alu_zero=0 -> taken.
3. Jump and register jump.
   - instr=32'h08000123 -> pc_control=001, jump_address=26'h0000123.
   - instr=32'h03E00008 (JR $31) -> pc_control=010, reg_sel=31.
4. Fetch timeout. TIMEOUT_CYCLES=4, imem_ack never asserted -> fault=1 after 4 FETCH cycles; pc_control stays 000; rst=0 returns to IDLE with fault=0.
5. Reset mid-handshake. Assert rst=0 during FETCH with imem_req=1 -> on the next edge imem_req=0, ir=0, retired=0, state IDLE; an imem_ack arriving after reset is ignored.
6. HALT and stop.
   - instr=32'hFC000000 -> ir_valid pulse, then halted=1 with no UPDATE and retired unchanged.
   - In a separate run, start=0 during UPDATE -> next state is IDLE, pc_control=000.
